// File: rtl/wramp_serial_tx.sv
// wramp_serial_tx: memory-mapped 8N1 serial transmitter with a small TX FIFO.
// Revision 1.0
`default_nettype none

module wramp_serial_tx #(
  parameter logic [19:0] BASE_ADDR  = 20'h70000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk,
  input  logic        rst_sync,
  input  logic [19:0] mem_address,
  input  logic        mem_write_en,
  input  logic [31:0] mem_write_value,
  output logic        dev_sel,
  output logic [31:0] dev_read_value,
  output logic        tx_out,
  output logic        irq
);

  localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [19:0] offset;
  logic [1:0]  reg_off;
  logic        wr;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        busy;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic [15:0] divisor;
  logic        enable;
  logic        irq_en;
  logic        overflow;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] div_cnt;
  logic [15:0] div_nxt;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_nxt;
  logic [7:0]  shreg;
  logic [7:0]  shreg_nxt;
  logic [15:0] reload;
  logic        bit_end;
  logic        tx_d;
  logic        irq_d;

  // Upper write-data bits have no register behind them.
  logic unused_bits;
  assign unused_bits = ^mem_write_value[31:16];

  // Offset compare keeps the window test to one subtract.
  assign offset   = mem_address - BASE_ADDR;
  assign dev_sel  = (offset[19:2] == 18'd0);
  assign reg_off  = offset[1:0];
  assign wr       = mem_write_en && dev_sel;
  assign push_req = wr && (reg_off == 2'd0);

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign busy    = (state != S_IDLE);
  assign reload  = (divisor == 16'd0) ? 16'd0 : (divisor - 16'd1);
  assign bit_end = (div_cnt == 16'd0);

  assign pop  = enable && !empty &&
                ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign push = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= mem_write_value[7:0];
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      divisor  <= DIV_RESET;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end else if (wr && (reg_off == 2'd1) && mem_write_value[3]) begin
        overflow <= 1'b0;
      end
      if (wr && (reg_off == 2'd2)) begin
        divisor <= mem_write_value[15:0];
      end
      if (wr && (reg_off == 2'd3)) begin
        enable <= mem_write_value[0];
        irq_en <= mem_write_value[1];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state   <= S_IDLE;
      div_cnt <= 16'd0;
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
      tx_out  <= 1'b1;
      irq     <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      tx_out  <= tx_d;
      irq     <= irq_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    if (pop) begin
      state_nxt = S_START;
      div_nxt   = reload;
      bit_nxt   = 3'd0;
      shreg_nxt = fifo_mem[rd_ptr];
    end else if (state != S_IDLE) begin
      if (bit_end) begin
        div_nxt = reload;
        case (state)
          S_START: state_nxt = S_DATA;
          S_DATA: begin
            shreg_nxt = {1'b0, shreg[7:1]};
            bit_nxt   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_nxt = S_STOP;
            end
          end
          default: state_nxt = S_IDLE;
        endcase
      end else begin
        div_nxt = div_cnt - 16'd1;
      end
    end
  end

  // Outputs: tx is registered from the next-state view so the line is glitch-free.
  always_comb begin
    tx_d = 1'b1;
    case (state_nxt)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_nxt[0];
      default: tx_d = 1'b1;
    endcase
    irq_d = irq_en && empty && (state == S_IDLE);
  end

  always_comb begin
    dev_read_value = 32'd0;
    if (dev_sel) begin
      case (reg_off)
        2'd1:    dev_read_value = {28'd0, overflow, empty, busy, !full};
        2'd2:    dev_read_value = {16'd0, divisor};
        2'd3:    dev_read_value = {30'd0, irq_en, enable};
        default: dev_read_value = 32'd0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wramp_serial_tx.sv
// Directed testbench for wramp_serial_tx.
`default_nettype none

module tb_wramp_serial_tx;

  localparam logic [19:0] BASE = 20'h70000;

  logic        clk = 1'b0;
  logic        rst_sync = 1'b1;
  logic [19:0] mem_address = 20'd0;
  logic        mem_write_en = 1'b0;
  logic [31:0] mem_write_value = 32'd0;
  logic        dev_sel;
  logic [31:0] dev_read_value;
  logic        tx_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  wramp_serial_tx #(
    .BASE_ADDR (20'h70000),
    .FIFO_DEPTH(4),
    .DIV_RESET (16'd16)
  ) dut (
    .clk            (clk),
    .rst_sync       (rst_sync),
    .mem_address    (mem_address),
    .mem_write_en   (mem_write_en),
    .mem_write_value(mem_write_value),
    .dev_sel        (dev_sel),
    .dev_read_value (dev_read_value),
    .tx_out         (tx_out),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [19:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_address     = a;
    mem_write_value = d;
    mem_write_en    = 1'b1;
    @(negedge clk);
    mem_write_en    = 1'b0;
  endtask

  task automatic rd(input logic [19:0] a, output logic [31:0] v);
    mem_address = a;
    #1;
    v = dev_read_value;
  endtask

  // Samples one frame starting at the next falling edge; also checks busy and optionally irq low.
  task automatic expect_frame(input logic [7:0] data, input int div, input bit chk_irq0, input string name);
    logic exp_bit;
    mem_address = BASE + 20'd1;
    for (int i = 0; i < 10; i++) begin
      exp_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : data[i-1];
      for (int j = 0; j < div; j++) begin
        @(negedge clk);
        checks++;
        if (tx_out !== exp_bit) begin
          errors++;
          $display("FAIL %s tx bit%0d clk%0d: got %b expected %b", name, i, j, tx_out, exp_bit);
        end
        checks++;
        if (dev_read_value[1] !== 1'b1) begin
          errors++;
          $display("FAIL %s busy bit%0d clk%0d: got %b expected 1", name, i, j, dev_read_value[1]);
        end
        if (chk_irq0) begin
          checks++;
          if (irq !== 1'b0) begin
            errors++;
            $display("FAIL %s irq in frame bit%0d: got %b expected 0", name, i, irq);
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    repeat (3) @(negedge clk);
    rst_sync = 1'b0;
    checks++;
    if (tx_out !== 1'b1 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: tx=%b irq=%b expected tx=1 irq=0", tx_out, irq);
    end
    rd(BASE + 20'd1, v);
    checks++;
    if (v !== 32'h5) begin
      errors++;
      $display("FAIL reset status: got %h expected 00000005", v);
    end
    rd(BASE + 20'd2, v);
    checks++;
    if (v !== 32'h10) begin
      errors++;
      $display("FAIL reset divisor: got %h expected 00000010", v);
    end
    rd(BASE + 20'd3, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL reset control: got %h expected 00000000", v);
    end
    rd(BASE, v);
    checks++;
    if (v !== 32'h0 || dev_sel !== 1'b1) begin
      errors++;
      $display("FAIL txdata read: got %h sel=%b expected 00000000 sel=1", v, dev_sel);
    end
  endtask

  task automatic test_basic_frame;
    logic [31:0] v;
    wr(BASE + 20'd2, 32'd4);
    wr(BASE + 20'd3, 32'd1);
    wr(BASE, 32'h55);
    expect_frame(8'h55, 4, 1'b0, "basic");
    @(negedge clk);
    rd(BASE + 20'd1, v);
    checks++;
    if (v !== 32'h5 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL basic after frame: status=%h tx=%b expected 00000005 tx=1", v, tx_out);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    wr(BASE + 20'd3, 32'd0);
    for (int k = 1; k <= 5; k++) wr(BASE, 32'(k));
    rd(BASE + 20'd1, v);
    checks++;
    if (v !== 32'h8) begin
      errors++;
      $display("FAIL overflow status: got %h expected 00000008", v);
    end
    wr(BASE + 20'd1, 32'h8);
    rd(BASE + 20'd1, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL overflow clear: got %h expected 00000000", v);
    end
    wr(BASE + 20'd3, 32'd1);
    for (int k = 1; k <= 4; k++) expect_frame(8'(k), 4, 1'b0, "b2b");
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1) begin
        errors++;
        $display("FAIL overflow dropped byte: tx=%b expected 1", tx_out);
      end
    end
    rd(BASE + 20'd1, v);
    checks++;
    if (v !== 32'h5) begin
      errors++;
      $display("FAIL overflow final status: got %h expected 00000005", v);
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] v;
    wr(BASE + 20'd2, 32'd0);
    rd(BASE + 20'd2, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL divzero readback: got %h expected 00000000", v);
    end
    wr(BASE, 32'hA0);
    expect_frame(8'hA0, 1, 1'b0, "divzero");
    @(negedge clk);
    rd(BASE + 20'd1, v);
    checks++;
    if (v !== 32'h5 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL divzero after frame: status=%h tx=%b expected 00000005 tx=1", v, tx_out);
    end
  endtask

  task automatic test_irq;
    wr(BASE + 20'd2, 32'd2);
    wr(BASE + 20'd3, 32'd3);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq idle empty: got %b expected 1", irq);
    end
    wr(BASE, 32'h7E);
    expect_frame(8'h7E, 2, 1'b1, "irq");
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq at return to idle: got %b expected 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq rise: got %b expected 1", irq);
    end
    wr(BASE + 20'd3, 32'd1);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq drop: got %b expected 0", irq);
    end
  endtask

  task automatic test_decode;
    logic [31:0] v;
    rd(BASE + 20'd4, v);
    checks++;
    if (dev_sel !== 1'b0 || v !== 32'h0) begin
      errors++;
      $display("FAIL decode base+4: sel=%b data=%h expected sel=0 data=0", dev_sel, v);
    end
    rd(BASE - 20'd1, v);
    checks++;
    if (dev_sel !== 1'b0 || v !== 32'h0) begin
      errors++;
      $display("FAIL decode base-1: sel=%b data=%h expected sel=0 data=0", dev_sel, v);
    end
    wr(BASE + 20'd4, 32'hFF);
    wr(BASE - 20'd1, 32'hFF);
    repeat (30) begin
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1) begin
        errors++;
        $display("FAIL decode stray tx: got %b expected 1", tx_out);
      end
    end
    rd(BASE + 20'd1, v);
    checks++;
    if (dev_sel !== 1'b1 || v !== 32'h5) begin
      errors++;
      $display("FAIL decode status read: sel=%b data=%h expected sel=1 data=00000005", dev_sel, v);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] v;
    wr(BASE + 20'd2, 32'd4);
    wr(BASE + 20'd3, 32'd0);
    wr(BASE, 32'h00);
    wr(BASE, 32'h11);
    wr(BASE, 32'h22);
    wr(BASE + 20'd3, 32'd1);
    repeat (17) @(negedge clk);
    checks++;
    if (tx_out !== 1'b0) begin
      errors++;
      $display("FAIL midframe bit3: got %b expected 0", tx_out);
    end
    rst_sync = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || irq !== 1'b0) begin
      errors++;
      $display("FAIL midframe reset outputs: tx=%b irq=%b expected tx=1 irq=0", tx_out, irq);
    end
    rst_sync = 1'b0;
    rd(BASE + 20'd1, v);
    checks++;
    if (v !== 32'h5) begin
      errors++;
      $display("FAIL midframe status: got %h expected 00000005", v);
    end
    rd(BASE + 20'd2, v);
    checks++;
    if (v !== 32'h10) begin
      errors++;
      $display("FAIL midframe divisor: got %h expected 00000010", v);
    end
    repeat (40) begin
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1) begin
        errors++;
        $display("FAIL midframe output after reset: got %b expected 1", tx_out);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_overflow;
    test_div_zero;
    test_irq;
    test_decode;
    test_reset_mid_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
